// File: rtl/walloc_mul_ctrl.sv
// Issue/retire controller for the fixed-latency Booth/Wallace multiplier datapath.
// Optional perf counters are built when MUL_CTRL_PERF_EN is defined.
module walloc_mul_ctrl #(
    parameter int LAT       = 3,
    parameter int BUF_DEPTH = 4,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             dp_issue,
    output logic [64:0]      dp_a,
    output logic [64:0]      dp_b,
    input  logic [127:0]     dp_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [31:0]      perf_issue,
    output logic [31:0]      perf_stall
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(BUF_DEPTH);
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    logic [AW:0]                  r_occ;
    logic [LAT:1]                 r_vld_pipe;
    logic [LAT:1][2:0]            r_op_pipe;
    logic [LAT:1][TAG_W-1:0]      r_tag_pipe;
    logic [BUF_DEPTH-1:0][63:0]   r_data;
    logic [BUF_DEPTH-1:0][TAG_W-1:0] r_tags;
    logic [AW-1:0]                r_wptr;
    logic [AW-1:0]                r_rptr;
    logic [AW:0]                  r_cnt;

    logic                         w_issue;
    logic                         w_pop;
    logic                         w_wr;
    logic [63:0]                  w_ret_data;

    // A pop in the same cycle does not open a slot: occ only drops on the edge.
    assign in_ready  = (r_occ < L_DEPTH) && !flush;
    assign w_issue   = in_valid && in_ready;
    assign dp_issue  = w_issue;
    assign out_valid = (r_cnt != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_wr      = r_vld_pipe[LAT];
    assign out_data  = r_data[r_rptr];
    assign out_tag   = r_tags[r_rptr];
    assign busy      = (r_occ != '0);

    always_comb begin
        dp_a = '0;
        dp_b = '0;
        if (w_issue) begin
            case (in_op)
                OP_MULHSU: begin dp_a = {in_a[63], in_a}; dp_b = {1'b0, in_b}; end
                OP_MULHU:  begin dp_a = {1'b0, in_a};     dp_b = {1'b0, in_b}; end
                OP_MULW:   begin
                    dp_a = {{33{in_a[31]}}, in_a[31:0]};
                    dp_b = {{33{in_b[31]}}, in_b[31:0]};
                end
                default:   begin dp_a = {in_a[63], in_a}; dp_b = {in_b[63], in_b}; end
            endcase
        end
    end

    always_comb begin
        case (r_op_pipe[LAT])
            OP_MULH, OP_MULHSU, OP_MULHU: w_ret_data = dp_prod[127:64];
            OP_MULW:                      w_ret_data = {{32{dp_prod[31]}}, dp_prod[31:0]};
            default:                      w_ret_data = dp_prod[63:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + {{AW{1'b0}}, w_issue} - {{AW{1'b0}}, w_pop};
        end
    end

    // Tracking pipe mirrors the datapath latency; flush only kills the valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_op_pipe  <= '0;
            r_tag_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_issue;
            r_op_pipe[1]  <= in_op;
            r_tag_pipe[1] <= in_tag;
            for (int s = 2; s <= LAT; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_op_pipe[s]  <= r_op_pipe[s-1];
                r_tag_pipe[s] <= r_tag_pipe[s-1];
            end
            if (flush) r_vld_pipe <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_tags <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_data[r_wptr] <= w_ret_data;
                r_tags[r_wptr] <= r_tag_pipe[LAT];
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_wr && !flush && r_cnt == L_DEPTH));

`ifdef MUL_CTRL_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_issue)               r_perf_issue <= r_perf_issue + 32'd1;
            if (in_valid && !in_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issue = r_perf_issue;
    assign perf_stall = r_perf_stall;
`else
    assign perf_issue = '0;
    assign perf_stall = '0;
`endif

endmodule
